// File: rtl/joy_dir_filter_if.sv
// Joystick conditioner bus: raw player inputs in, conditioned directions/fire out.
// master = input source and output consumer, slave = the filter itself.
interface joy_dir_filter_if #(
  parameter int CHANNELS = 2
);
  logic [4*CHANNELS-1:0] dir_in;
  logic [CHANNELS-1:0]   fire_in;
  logic                  mode_8way;
  logic                  rotate;
  logic [CHANNELS-1:0]   autofire;
  logic [4*CHANNELS-1:0] dir_out;
  logic [CHANNELS-1:0]   fire_out;
  logic [CHANNELS-1:0]   change;

  modport master (
    output dir_in, fire_in, mode_8way, rotate, autofire,
    input  dir_out, fire_out, change
  );

  modport slave (
    input  dir_in, fire_in, mode_8way, rotate, autofire,
    output dir_out, fire_out, change
  );
endinterface

// File: rtl/joy_dir_filter.sv
// N-channel joystick conditioner: sync, debounce, optional 90 deg rotate, 4/8-way rules.
// Optional autofire on the fire button when JOY_AUTOFIRE_EN is defined.
module joy_dir_filter #(
  parameter int CHANNELS  = 2,
  parameter int DB_CYCLES = 4,
  parameter int AF_HALF   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  joy_dir_filter_if.slave  bus
);
  localparam int NB = 5 * CHANNELS;
  localparam int CW = $clog2(DB_CYCLES + 1);

  // Bit layout: directions in the low 4*CHANNELS bits, fire bits above them.
  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;
  logic [NB-1:0] stable;

  assign raw = {bus.fire_in, bus.dir_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  function automatic logic [3:0] pick_first(input logic [3:0] x);
    logic [3:0] r;
    r = 4'b0000;
    if (x[3])      r = 4'b1000;
    else if (x[2]) r = 4'b0100;
    else if (x[1]) r = 4'b0010;
    else if (x[0]) r = 4'b0001;
    return r;
  endfunction

  for (genvar gi = 0; gi < NB; gi++) begin : g_db
    logic [CW-1:0] cnt_q;
    logic          stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (s2_q[gi] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        stable_q <= s2_q[gi];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stable[gi] = stable_q;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [3:0] st;
    logic [3:0] rot;
    logic [3:0] new_bits;
    logic [3:0] cancel;
    logic [3:0] mask_d;
    logic [3:0] dir_d;
    logic [3:0] rot_prev_q;
    logic [3:0] mask_q;
    logic [3:0] dir_q;
    logic       change_q;
    logic       fire_st;
    logic       fire_q;

    assign st      = stable[4*gi +: 4];
    assign fire_st = stable[4*CHANNELS + gi];
    // {up,down,left,right}: rotated up=left, down=right, left=down, right=up
    assign rot     = bus.rotate ? {st[1], st[0], st[2], st[3]} : st;

    always_comb begin
      new_bits = rot & ~rot_prev_q;
      mask_d   = mask_q;
      // In 8-way the mask follows the held bits so a switch to 4-way has no gap.
      if (bus.mode_8way)            mask_d = pick_first(rot);
      else if (new_bits != 4'b0000) mask_d = pick_first(new_bits);
      else if (rot == 4'b0000)      mask_d = 4'b0000;
      else if ((rot & mask_q) == 4'b0000) mask_d = pick_first(rot);

      cancel[3:2] = (rot[3] & rot[2]) ? 2'b00 : rot[3:2];
      cancel[1:0] = (rot[1] & rot[0]) ? 2'b00 : rot[1:0];
      dir_d       = bus.mode_8way ? cancel : (rot & mask_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rot_prev_q <= 4'b0000;
        mask_q     <= 4'b0000;
        dir_q      <= 4'b0000;
        change_q   <= 1'b0;
      end else begin
        rot_prev_q <= rot;
        mask_q     <= mask_d;
        dir_q      <= dir_d;
        change_q   <= (dir_d != dir_q);
      end
    end

`ifdef JOY_AUTOFIRE_EN
    localparam int AW = $clog2(2 * AF_HALF);
    logic [AW-1:0] af_cnt_q;
    logic          af_active;

    assign af_active = fire_st & bus.autofire[gi];

    // Phase 0..AF_HALF-1 is the high half, so the first active cycle fires.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        af_cnt_q <= '0;
        fire_q   <= 1'b0;
      end else if (af_active) begin
        fire_q   <= (af_cnt_q < AW'(AF_HALF));
        af_cnt_q <= (af_cnt_q == AW'(2*AF_HALF - 1)) ? '0 : af_cnt_q + 1'b1;
      end else begin
        af_cnt_q <= '0;
        fire_q   <= fire_st;
      end
    end
`else
    logic unused_autofire;
    assign unused_autofire = bus.autofire[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fire_q <= 1'b0;
      else        fire_q <= fire_st;
    end
`endif

    assign bus.dir_out[4*gi +: 4] = dir_q;
    assign bus.change[gi]         = change_q;
    assign bus.fire_out[gi]       = fire_q;
  end
endmodule

// File: tb/tb_joy_dir_filter.sv
// Self-checking bench for joy_dir_filter: directed table, corner sequences and a
// randomized run against a cycle-level reference model.
module tb_joy_dir_filter;
  localparam int CH = 2;
  localparam int DB = 4;
  localparam int AF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  joy_dir_filter_if #(.CHANNELS(CH)) bus ();

  joy_dir_filter #(.CHANNELS(CH), .DB_CYCLES(DB), .AF_HALF(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [5*CH-1:0] hist[$];
  logic [5*CH-1:0] m_stable;
  logic [3:0]      m_held[CH];
  int              m_sel[CH];
  logic [4*CH-1:0] m_dir;
  logic [CH-1:0]   m_fire;
  logic [CH-1:0]   m_change;
  int              m_af[CH];

  typedef struct {
    string      name;
    logic [7:0] dir;
    logic       mode;
    logic       rot;
    logic [7:0] exp_dir;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_front('0);
    m_stable = '0;
    m_dir    = '0;
    m_fire   = '0;
    m_change = '0;
    for (int c = 0; c < CH; c++) begin
      m_held[c] = 4'b0;
      m_sel[c]  = -1;
      m_af[c]   = 0;
    end
  endtask

  // One clock edge: advance the model from pre-edge state, then compare all outputs.
  task automatic tick();
    logic [5*CH-1:0] raw;
    logic [4*CH-1:0] nd;
    logic [CH-1:0]   nf;
    logic [3:0]      st, held, pressed;
    logic            all_diff;
    @(posedge clk);
    raw = {bus.fire_in, bus.dir_in};
    nd = '0;
    nf = '0;
    for (int c = 0; c < CH; c++) begin
      st = m_stable[4*c +: 4];
      if (bus.rotate) begin
        held[3] = st[1]; held[2] = st[0]; held[1] = st[2]; held[0] = st[3];
      end else begin
        held = st;
      end
      pressed = held & ~m_held[c];
      if (bus.mode_8way) begin
        m_sel[c] = -1;
        for (int d = 3; d >= 0; d--) if (held[d] && m_sel[c] < 0) m_sel[c] = d;
        nd[4*c+3] = held[3] && !held[2];
        nd[4*c+2] = held[2] && !held[3];
        nd[4*c+1] = held[1] && !held[0];
        nd[4*c+0] = held[0] && !held[1];
      end else begin
        if (pressed != 0) begin
          m_sel[c] = -1;
          for (int d = 3; d >= 0; d--) if (pressed[d] && m_sel[c] < 0) m_sel[c] = d;
        end else if (m_sel[c] < 0 || !held[m_sel[c]]) begin
          m_sel[c] = -1;
          for (int d = 3; d >= 0; d--) if (held[d] && m_sel[c] < 0) m_sel[c] = d;
        end
        if (m_sel[c] >= 0) nd[4*c + m_sel[c]] = 1'b1;
      end
      m_held[c] = held;
`ifdef JOY_AUTOFIRE_EN
      if (m_stable[4*CH+c] && bus.autofire[c]) begin
        nf[c] = (m_af[c] % (2*AF)) < AF;
        m_af[c]++;
      end else begin
        nf[c] = m_stable[4*CH+c];
        m_af[c] = 0;
      end
`else
      nf[c] = m_stable[4*CH+c];
`endif
      m_change[c] = (nd[4*c +: 4] != m_dir[4*c +: 4]);
    end
    m_dir  = nd;
    m_fire = nf;
    // A bit's stable value flips once the synchronised input has disagreed for DB samples.
    hist.push_front(raw);
    while (hist.size() > DB + 2) void'(hist.pop_back());
    for (int b = 0; b < 5*CH; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    #1;
    chk("cycle", {20'b0, bus.dir_out, bus.fire_out, bus.change},
                 {20'b0, m_dir, m_fire, m_change});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {20'b0, bus.dir_out, bus.fire_out, bus.change}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt[12];
  int   lat, chg, ups, zeros, rises, highs;
  logic prev_up, prev_f;

  initial begin
    vt[0]  = '{"4w_left",      8'h02, 1'b0, 1'b0, 8'h02};
    vt[1]  = '{"4w_left_up",   8'h0A, 1'b0, 1'b0, 8'h08};
    vt[2]  = '{"4w_fallback",  8'h02, 1'b0, 1'b0, 8'h02};
    vt[3]  = '{"4w_idle",      8'h00, 1'b0, 1'b0, 8'h00};
    vt[4]  = '{"4w_up_right",  8'h09, 1'b0, 1'b0, 8'h08};
    vt[5]  = '{"idle",         8'h00, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{"8w_diag",      8'h09, 1'b1, 1'b0, 8'h09};
    vt[7]  = '{"8w_ud_cancel", 8'h0E, 1'b1, 1'b0, 8'h02};
    vt[8]  = '{"8w_lr_cancel", 8'h03, 1'b1, 1'b0, 8'h00};
    vt[9]  = '{"idle2",        8'h00, 1'b0, 1'b0, 8'h00};
    vt[10] = '{"rot_left_up",  8'h20, 1'b0, 1'b1, 8'h80};
    vt[11] = '{"rot_up_right", 8'h80, 1'b0, 1'b1, 8'h10};

    bus.dir_in = '0; bus.fire_in = '0; bus.mode_8way = 1'b0;
    bus.rotate = 1'b0; bus.autofire = '0;

    // Reset with every input asserted, then measure first-change latency.
    bus.dir_in = '1; bus.fire_in = '1;
    apply_reset();
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.dir_out != 0 && lat == 0) lat = n;
    end
    chk("reset_latency", lat, 7);
    chk("reset_dir", {24'b0, bus.dir_out}, 32'h88);
    chk("reset_fire", {30'b0, bus.fire_out}, 32'h3);
    bus.dir_in = '0; bus.fire_in = '0;
    repeat (12) tick();

    // Glitch rejection: 3-clock pulse dropped, 4-clock pulse passes once.
    bus.dir_in = 8'h08;
    repeat (3) tick();
    bus.dir_in = 8'h00;
    chg = 0;
    for (int n = 0; n < 14; n++) begin tick(); chg += bus.change[0]; end
    chk("glitch3_changes", chg, 0);
    bus.dir_in = 8'h08;
    repeat (4) tick();
    bus.dir_in = 8'h00;
    chg = 0; ups = 0; prev_up = 1'b0;
    for (int n = 0; n < 16; n++) begin
      tick();
      chg += bus.change[0];
      if (bus.dir_out[3] && !prev_up) ups++;
      prev_up = bus.dir_out[3];
    end
    chk("glitch4_changes", chg, 2);
    chk("glitch4_up_once", ups, 1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      bus.dir_in = vt[i].dir; bus.mode_8way = vt[i].mode; bus.rotate = vt[i].rot;
      repeat (10) tick();
      chk(vt[i].name, {24'b0, bus.dir_out}, {24'b0, vt[i].exp_dir});
    end
    bus.rotate = 1'b0; bus.dir_in = '0;
    repeat (10) tick();

    // Fallback must not produce an empty cycle.
    bus.dir_in = 8'h02; repeat (10) tick();
    bus.dir_in = 8'h0A; repeat (10) tick();
    bus.dir_in = 8'h02;
    zeros = 0;
    for (int n = 0; n < 12; n++) begin tick(); if (bus.dir_out[3:0] == 4'h0) zeros++; end
    chk("fallback_gap", zeros, 0);
    chk("fallback_dir", {28'b0, bus.dir_out[3:0]}, 32'h2);
    bus.dir_in = '0; repeat (10) tick();

    // Fire with autofire request held.
    bus.fire_in = 2'b01; bus.autofire = 2'b01;
    lat = 0;
    for (int n = 0; n < 20 && !bus.fire_out[0]; n++) begin tick(); lat++; end
    chk("fire_latency", lat, 7);
    rises = 1; highs = 1; prev_f = 1'b1;
    for (int n = 1; n < 64; n++) begin
      tick();
      if (bus.fire_out[0] && !prev_f) rises++;
      highs += bus.fire_out[0];
      prev_f = bus.fire_out[0];
    end
`ifdef JOY_AUTOFIRE_EN
    chk("autofire_rises", rises, 4);
    chk("autofire_highs", highs, 32);
`else
    chk("fire_steady_rises", rises, 1);
    chk("fire_steady_highs", highs, 64);
`endif
    bus.fire_in = '0;
    repeat (DB + 3) tick();
    chk("fire_release", {30'b0, bus.fire_out}, 32'h0);
    bus.autofire = '0;

    // Randomized run with a mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) bus.dir_in = 8'($urandom);
      if ($urandom_range(7) == 0) bus.fire_in = 2'($urandom);
      if ($urandom_range(15) == 0) bus.autofire = 2'($urandom);
      if ($urandom_range(63) == 0) bus.mode_8way = ~bus.mode_8way;
      if ($urandom_range(63) == 0) bus.rotate = ~bus.rotate;
      if (n == 1500) apply_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
